bcp_impl_queue: RTL and testbench
=================================

# bcp_impl_queue

Parametrised implication queue for the hardware BCP engine. It collects implied literals from `LANES` parallel BCP checker lanes over a valid/ready handshake and arbitrates them round-robin, one literal per cycle, into a `DEPTH`-entry FIFO. The decision/propagation controller drains the FIFO. It optionally detects conflicts, meaning the same variable implied with opposite polarity, and halts collection until the controller clears them.

## Interface
- `LANES`, 4: number of checker lanes (≥1).
- `VAR_W`, 8: variable index width; literal width `LIT_W = VAR_W+1`, as `{polarity, var}`.
- `DEPTH`, 16: FIFO entries, power of two ≥2; `CNT_W = $clog2(DEPTH)+1`.

Ports:
- `clock` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `en` in 1: level; enables collection.
- `clear` in 1: pulse; flushes FIFO, leaves CONFLICT.
- `lane_valid` in LANES: lane i offers a literal.
- `lane_lit` in LANES*LIT_W: lane i literal at bits [i*LIT_W +: LIT_W].
- `lane_ready` out LANES: one-hot grant, combinational.
- `pop` in 1: consume head.
- `out_valid` out 1: head valid (= !empty).
- `out_lit` out LIT_W: head literal; 0 when empty.
- `count` out CNT_W: occupancy.
- `full`, `empty` out 1: registered flags.
- `busy` out 1: state != IDLE.
- `conflict` out 1: in CONFLICT state.
- `conflict_var` out VAR_W: variable that conflicted.

## Operation
- FSM states: IDLE, COLLECT, CONFLICT.
  - IDLE→COLLECT when `en`=1.
  - COLLECT→IDLE when `en`=0; contents are kept.
  - COLLECT→CONFLICT on a detected conflict.
  - CONFLICT→IDLE on `clear`.
  - `clear` in any state empties the FIFO (pointers and count set to 0). In COLLECT, `clear` flushes and the state stays COLLECT.
- Grant: `lane_ready` goes to the first valid lane at or after `rr_ptr`, wrapping. Grant requires state COLLECT, !full and !clear. A push happens when the granted lane's valid and ready are both high. On a push, `rr_ptr` becomes granted+1 mod LANES. `rr_ptr` does not change otherwise.
- Lane rule: a lane holds `lane_valid` and `lane_lit` stable until it is granted. Ungranted lanes wait without loss.
- FIFO: register array with wrapping read and write pointers of `$clog2(DEPTH)` bits. `out_lit` is a show-ahead read of `mem[rd_ptr]`.
- Pop: takes effect when `pop` && !empty, in any state. A pop while empty is ignored and does not change state.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. With full and pop, no push occurs that cycle because ready is low.
- `clear` wins over push and pop in the same cycle.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, pointers 0, `count` 0, `empty` 1, `full` 0, `out_valid` 0, `out_lit` 0, `lane_ready` 0, `busy` 0, `conflict` 0, `conflict_var` 0. Memory is not cleared; `out_lit` is gated by empty.
- Reset mid-operation: all of the above take effect on the next edge. Queued data is discarded.
- Latency: a literal pushed at edge N appears on `out_lit` with `out_valid`=1 after edge N if the FIFO was empty.
- `full`, `empty` and `count` update on the same edge as the push or pop.
- `lane_ready` is combinational from state, `full`, `clear`, `lane_valid` and `rr_ptr`. There is no path from `lane_lit` to `lane_ready`.
- Maximum throughput: one push and one pop per cycle.

## Configuration
- `BCP_CONFLICT_DETECT_EN` defined:
  - Each literal being pushed is compared against every occupied entry, using contents before any pop that cycle, including an entry being popped.
  - Match rule: equal var, opposite polarity.
  - On a match the literal is not written, but the lane handshake still completes and `rr_ptr` still advances.
  - `conflict_var` is loaded with the var, and the state goes to CONFLICT on the next edge.
  - Same-polarity duplicates are written normally.
- Not defined: no comparators are built, every push is written, `conflict` and `conflict_var` stay 0, and CONFLICT is unreachable.

## Test plan
- Reset, then `en`=1 and lane 2 offers 9'h105 → `lane_ready`=4'b0100. The next cycle gives `out_valid`=1, `out_lit`=9'h105, `count`=1.
- All 4 lanes valid continuously, `rr_ptr`=0, no pop → grants go 0,1,2,3,0,… one per cycle. At `count`=16, `full`=1 and `lane_ready`=0.
- Full FIFO, `pop` and lane valid held → pop that cycle with no push. The next cycle pushes, and `count` returns to 16.
- Empty, pop only → ignored, `count`=0. Then push and pop at `count`=3 → `count` stays 3 and the head advances.
- With the macro: queue holds 9'h007, lane 1 offers 9'h107 → not written, `conflict`=1, `conflict_var`=8'h07, `count` unchanged, `lane_ready`=0. Then `clear` → IDLE, `count`=0. Without the macro the same stimulus gives `count`+1 and `conflict`=0.
- Synchronous reset asserted with `count`=5 in COLLECT → next edge gives `count`=0, `empty`=1, `busy`=0. A reset pulse between edges has no effect.

Source files
------------

// File: rtl/bcp_impl_queue.sv
// Implication queue: round-robin collection of implied literals from LANES checker lanes into a DEPTH-entry FIFO.
// Optional conflict detection (opposite-polarity duplicate of a queued var) is enabled by defining BCP_CONFLICT_DETECT_EN.
module bcp_impl_queue #(
  parameter  int LANES = 4,
  parameter  int VAR_W = 8,
  parameter  int DEPTH = 16,
  localparam int LIT_W = VAR_W + 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [LANES-1:0]       lane_valid,
  input  logic [LANES*LIT_W-1:0] lane_lit,
  output logic [LANES-1:0]       lane_ready,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [LIT_W-1:0]       out_lit,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic                   conflict,
  output logic [VAR_W-1:0]       conflict_var
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RR_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, CONFLICT} state_t;

  state_t            state, state_nxt;
  logic [RR_W-1:0]   rr_ptr, grant_idx;
  logic              grant_any, push, do_pop, do_write, hit;
  logic [LIT_W-1:0]  push_lit;
  logic [LIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_nxt;

  // Round-robin search starts at rr_ptr; lane_lit never feeds the grant.
  always_comb begin
    logic [RR_W-1:0] idx;
    idx        = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    lane_ready = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = RR_W'((int'(rr_ptr) + k) % LANES);
      if (!grant_any && lane_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (state == COLLECT && !full && !clear && grant_any)
      lane_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    push_lit = '0;
    for (int k = 0; k < LANES; k++)
      if (lane_ready[k]) push_lit = lane_lit[k*LIT_W +: LIT_W];
  end

  assign push   = |(lane_ready & lane_valid);
  assign do_pop = pop && !empty && !clear;

`ifdef BCP_CONFLICT_DETECT_EN
  // Compare against every occupied slot as it stands before this cycle's pop.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset = '0;
    hit    = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      offset = PTR_W'(j) - rd_ptr;
      if ({1'b0, offset} < count &&
          mem[j][VAR_W-1:0] == push_lit[VAR_W-1:0] &&
          mem[j][VAR_W] != push_lit[VAR_W])
        hit = 1'b1;
    end
    hit = hit && push;
  end

  always_ff @(posedge clock) begin
    if (!reset)   conflict_var <= '0;
    else if (hit) conflict_var <= push_lit[VAR_W-1:0];
  end
`else
  assign hit          = 1'b0;
  assign conflict_var = '0;
`endif

  assign do_write = push && !hit;

  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (do_write && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_write && do_pop)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en) state_nxt = COLLECT;
      COLLECT:  if (hit) state_nxt = CONFLICT;
                else if (!en) state_nxt = IDLE;
      CONFLICT: if (clear) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) rr_ptr <= RR_W'((int'(grant_idx) + 1) % LANES);
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; out_lit is gated by empty instead.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= push_lit;
  end

  assign out_valid = !empty;
  assign out_lit   = empty ? '0 : mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign conflict  = (state == CONFLICT);

endmodule

// File: tb/tb_bcp_impl_queue.sv
// Bench for bcp_impl_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_bcp_impl_queue;
  localparam int LANES = 4, VAR_W = 8, DEPTH = 16, LIT_W = 9, CNT_W = 5;

  logic clock = 0, reset = 0, en = 0, clear = 0, pop = 0;
  logic [LANES-1:0]       lane_valid = '0;
  logic [LANES*LIT_W-1:0] lane_lit   = '0;
  logic [LANES-1:0]       lane_ready;
  logic                   out_valid, full, empty, busy, conflict;
  logic [LIT_W-1:0]       out_lit;
  logic [CNT_W-1:0]       count;
  logic [VAR_W-1:0]       conflict_var;

  bcp_impl_queue #(.LANES(LANES), .VAR_W(VAR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear),
    .lane_valid(lane_valid), .lane_lit(lane_lit), .lane_ready(lane_ready),
    .pop(pop), .out_valid(out_valid), .out_lit(out_lit), .count(count),
    .full(full), .empty(empty), .busy(busy), .conflict(conflict),
    .conflict_var(conflict_var)
  );

  always #5 clock = ~clock;

  // Reference model: queue contents, state (0 idle, 1 collect, 2 conflict), rr pointer
  logic [LIT_W-1:0] mq[$];
  int               m_state = 0, m_rr = 0, last_grant = -1;
  logic [VAR_W-1:0] m_cvar = '0;
  bit               chk_en = 1'b1;
  int               checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (m_state != 1 || mq.size() >= DEPTH || clear) return -1;
    for (int k = 0; k < LANES; k++)
      if (lane_valid[(m_rr + k) % LANES]) return (m_rr + k) % LANES;
    return -1;
  endfunction

  function automatic logic [LANES-1:0] m_ready();
    logic [LANES-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    int g;
    bit hit, p;
    logic [LIT_W-1:0] lit;
    if (!reset) begin
      mq.delete(); m_state = 0; m_rr = 0; m_cvar = '0; last_grant = -1;
      return;
    end
    g   = m_grant();
    hit = 1'b0;
    p   = pop && mq.size() > 0 && !clear;
    lit = (g >= 0) ? lane_lit[g*LIT_W +: LIT_W] : '0;
`ifdef BCP_CONFLICT_DETECT_EN
    if (g >= 0)
      foreach (mq[i])
        if (mq[i][VAR_W-1:0] == lit[VAR_W-1:0] && mq[i][VAR_W] != lit[VAR_W]) hit = 1'b1;
`endif
    if (clear) mq.delete();
    else begin
      if (p) void'(mq.pop_front());
      if (g >= 0 && !hit) mq.push_back(lit);
    end
    if (g >= 0) m_rr = (g + 1) % LANES;
    if (hit) m_cvar = lit[VAR_W-1:0];
    case (m_state)
      0: if (en) m_state = 1;
      1: if (hit) m_state = 2; else if (!en) m_state = 0;
      default: if (clear) m_state = 0;
    endcase
    last_grant = g;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("lane_ready", 32'(lane_ready), 32'(m_ready()));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("out_lit", 32'(out_lit), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("busy", 32'(busy), 32'(m_state != 0));
      check("conflict", 32'(conflict), 32'(m_state == 2));
      check("conflict_var", 32'(conflict_var), 32'(m_cvar));
    end
  end

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_lane(input int i, input logic [LIT_W-1:0] lit);
    lane_valid[i] = 1'b1;
    lane_lit[i*LIT_W +: LIT_W] = lit;
  endtask

  task automatic restart();
    lane_valid = '0; pop = 0; clear = 0;
    reset = 0; step();
    reset = 1; en = 1; step();
  endtask

  initial begin
    logic [LANES-1:0] e;
    int nextv, pop_pct;
    int pct_tab[6] = '{10, 50, 90, 30, 70, 20};

    // Reset state
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_busy", 32'(busy), 0);
    reset = 1; en = 1; step();

    // Single literal from lane 2
    set_lane(2, 9'h105); #1;
    check("t1_ready", 32'(lane_ready), 32'h4);
    step(); lane_valid = '0; #1;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_lit", 32'(out_lit), 32'h105);
    check("t1_count", 32'(count), 1);

    // Round-robin fill to full
    restart();
    for (int k = 0; k < LANES; k++) set_lane(k, LIT_W'(k));
    nextv = LANES;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e = LANES'(1 << (i % LANES));
      check("rr_grant", 32'(lane_ready), 32'(e));
      step();
      set_lane(i % LANES, LIT_W'(nextv)); nextv++;
    end
    #1;
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_ready", 32'(lane_ready), 0);
    check("fill_head", 32'(out_lit), 0);

    // Pop while full: no push that cycle, refill the next
    pop = 1; #1;
    check("fullpop_ready", 32'(lane_ready), 0);
    step(); pop = 0; #1;
    check("fullpop_count", 32'(count), 15);
    check("fullpop_head", 32'(out_lit), 1);
    step(); #1;
    check("refill_count", 32'(count), 16);

    // Pop on empty is ignored; push+pop keeps count
    restart();
    pop = 1; step(); pop = 0; #1;
    check("emptypop_count", 32'(count), 0);
    set_lane(0, 9'h011); step();
    set_lane(0, 9'h012); step();
    set_lane(0, 9'h013); step();
    lane_valid = '0; #1;
    check("p3_count", 32'(count), 3);
    check("p3_head", 32'(out_lit), 32'h011);
    set_lane(1, 9'h014); pop = 1; step();
    pop = 0; lane_valid = '0; #1;
    check("pp_count", 32'(count), 3);
    check("pp_head", 32'(out_lit), 32'h012);

    // Opposite-polarity duplicate
    restart();
    set_lane(0, 9'h007); step();
    lane_valid = '0; set_lane(1, 9'h107); step();
    lane_valid = '0; set_lane(2, 9'h020); #1;
`ifdef BCP_CONFLICT_DETECT_EN
    check("cf_conflict", 32'(conflict), 1);
    check("cf_var", 32'(conflict_var), 32'h07);
    check("cf_count", 32'(count), 1);
    check("cf_ready", 32'(lane_ready), 0);
    clear = 1; step(); clear = 0; #1;
    check("cf_clear_busy", 32'(busy), 0);
    check("cf_clear_count", 32'(count), 0);
`else
    check("nocf_count", 32'(count), 2);
    check("nocf_conflict", 32'(conflict), 0);
`endif
    lane_valid = '0;

    // Synchronous reset mid-operation; a pulse between edges is ignored
    restart();
    for (int k = 0; k < 5; k++) begin set_lane(3, LIT_W'(9'h030 + k)); step(); end
    lane_valid = '0; #1;
    check("r5_count", 32'(count), 5);
    reset = 0; #1; reset = 1;
    step(); #1;
    check("glitch_count", 32'(count), 5);
    check("glitch_busy", 32'(busy), 1);
    reset = 0; step(); reset = 1; #1;
    check("rst5_count", 32'(count), 0);
    check("rst5_empty", 32'(empty), 1);
    check("rst5_busy", 32'(busy), 0);

    // Randomized traffic
    restart();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pop_pct = pct_tab[(cyc / 500) % 6];
      reset = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 9) != 0);
      clear = en && ((m_state == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0));
      pop   = ($urandom_range(0, 99) < pop_pct);
      for (int i = 0; i < LANES; i++) begin
        if (!lane_valid[i] || last_grant == i) begin
          lane_valid[i] = ($urandom_range(0, 3) != 0);
          lane_lit[i*LIT_W +: LIT_W] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
        end
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
